// File: rtl/cvp_vec_pkg.sv
// Shared vector-core types and default geometry for the CVP vector unit.
package cvp_vec_pkg;
  localparam int VEC_LANES  = 16;
  localparam int VEC_ELEM_W = 16;
  localparam int VEC_ADDR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_STORE,
    S_DONE
  } seq_state_e;
endpackage

// File: rtl/vec_addr_gen.sv
// Strided address accumulator: loads Base, then adds Stride on each advance (silent wrap).
module vec_addr_gen
  import cvp_vec_pkg::*;
#(
  parameter int ADDR_W = VEC_ADDR_W
) (
  input  logic              Clk1,
  input  logic              Reset_n,
  input  logic              Load,
  input  logic              Advance,
  input  logic [ADDR_W-1:0] Base,
  input  logic [ADDR_W-1:0] Stride,
  output logic [ADDR_W-1:0] Addr
);

  always_ff @(posedge Clk1 or negedge Reset_n) begin
    if (!Reset_n) begin
      Addr <= '0;
    end else if (Load) begin
      Addr <= Base;
    end else if (Advance) begin
      Addr <= Addr + Stride;
    end
  end

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer between the execute stage and the single-port memory bus.
//   state  | meaning
//   IDLE   | waiting for Start
//   LOAD   | RD presented for element idx; advances on MemReady
//   DRAIN  | capturing the final read element, no strobe
//   STORE  | WR presented for element idx; advances on MemReady
//   DONE   | one-cycle completion pulse
module vec_mem_seq
  import cvp_vec_pkg::*;
#(
  parameter int LANES  = VEC_LANES,
  parameter int ELEM_W = VEC_ELEM_W,
  parameter int ADDR_W = VEC_ADDR_W,
  localparam int LEN_W = $clog2(LANES)
) (
  input  logic                    Clk1,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic                    IsStore,
  input  logic [ADDR_W-1:0]       Base,
  input  logic [ADDR_W-1:0]       Stride,
  input  logic [LEN_W-1:0]        Len,
  input  logic [LANES*ELEM_W-1:0] VecIn,
  input  logic                    MemReady,
  input  logic [ELEM_W-1:0]       DataIn,
  output logic [ADDR_W-1:0]       Addr,
  output logic                    RD,
  output logic                    WR,
  output logic [ELEM_W-1:0]       dataOut,
  output logic                    Busy,
  output logic                    Done,
  output logic [LANES*ELEM_W-1:0] VecOut
);

  seq_state_e              state_q, state_d;
  logic [LEN_W-1:0]        idx_q, idx_d;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cap_idx_q;
  logic                    pend_q;
  logic [LANES*ELEM_W-1:0] vec_in_q;
  logic [LANES*ELEM_W-1:0] store_src;
  logic [ELEM_W-1:0]       store_lane;
  logic                    accept, xfer, last;

  assign accept = (state_q == S_IDLE) && Start;
  assign xfer   = ((state_q == S_LOAD) || (state_q == S_STORE)) && MemReady;
  assign last   = (idx_q == len_q);

  // On the accept edge the latched copy is not yet valid, so lane 0 comes straight from VecIn.
  assign store_src  = accept ? VecIn : vec_in_q;
  assign store_lane = store_src[idx_d*ELEM_W +: ELEM_W];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = IsStore ? S_STORE : S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (last) state_d = S_DRAIN;
          else      idx_d   = idx_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_STORE: begin
        if (xfer) begin
          if (last) state_d = S_DONE;
          else      idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  vec_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .Clk1    (Clk1),
    .Reset_n (Reset_n),
    .Load    (accept),
    .Advance (xfer),
    .Base    (Base),
    .Stride  (Stride),
    .Addr    (Addr)
  );

  always_ff @(posedge Clk1 or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      cap_idx_q <= '0;
      pend_q    <= 1'b0;
      vec_in_q  <= '0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      dataOut   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      VecOut    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      RD        <= (state_d == S_LOAD);
      WR        <= (state_d == S_STORE);
      Busy      <= (state_d != S_IDLE);
      Done      <= (state_d == S_DONE);
      pend_q    <= (state_q == S_LOAD) && MemReady;
      cap_idx_q <= idx_q;
      if (accept) begin
        len_q    <= Len;
        vec_in_q <= VecIn;
      end
      if (state_d == S_STORE) dataOut <= store_lane;
      if (pend_q) VecOut[cap_idx_q*ELEM_W +: ELEM_W] <= DataIn;
      if (accept && !IsStore) begin
        for (int l = 0; l < LANES; l++) begin
          if (l > int'(Len)) VecOut[l*ELEM_W +: ELEM_W] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Self-checking bench for vec_mem_seq: table vectors, hand sequences and randomized ops vs a cycle model.
module tb_vec_mem_seq;
  localparam int LANES = 16;
  localparam int EW    = 16;
  localparam int AW    = 16;
  localparam int VW    = LANES * EW;

  logic          Clk1 = 1'b0;
  logic          Reset_n;
  logic          Start, IsStore, MemReady;
  logic [AW-1:0] Base, Stride;
  logic [3:0]    Len;
  logic [VW-1:0] VecIn;
  logic [EW-1:0] DataIn;
  logic [AW-1:0] Addr;
  logic          RD, WR, Busy, Done;
  logic [EW-1:0] dataOut;
  logic [VW-1:0] VecOut;

  int tests = 0;
  int fails = 0;
  logic [VW-1:0] exp_vec = '0;

  vec_mem_seq #(.LANES(LANES), .ELEM_W(EW), .ADDR_W(AW)) dut (
    .Clk1(Clk1), .Reset_n(Reset_n), .Start(Start), .IsStore(IsStore),
    .Base(Base), .Stride(Stride), .Len(Len), .VecIn(VecIn),
    .MemReady(MemReady), .DataIn(DataIn), .Addr(Addr), .RD(RD), .WR(WR),
    .dataOut(dataOut), .Busy(Busy), .Done(Done), .VecOut(VecOut)
  );

  always #5 Clk1 = ~Clk1;

  typedef struct {
    logic        st;
    logic [15:0] base;
    logic [15:0] stride;
    logic [3:0]  len;
    logic [63:0] stall;
    bit          busy_start;
    int          exp_done;
  } vec_t;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a + 16'h0100;
  endfunction

  function automatic logic [15:0] addr_of(input logic [15:0] b, input logic [15:0] s, input int i);
    logic [31:0] p;
    p = i * s;
    return b + p[15:0];
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one operation; ready pattern comes from stall mask or random draws; done cycle from the model.
  task automatic run_op(input logic st, input logic [15:0] base, input logic [15:0] stride,
                        input logic [3:0] len, input logic [VW-1:0] vec, input logic [63:0] stall,
                        input bit rnd, input bit busy_start, input int tbl_done);
    bit   rdy [256];
    int   idx_at [256];
    int   i, c, c_last, done_c, seen_done;
    logic pend;
    logic [15:0] pend_addr;
    for (int k = 0; k < 256; k++)
      rdy[k] = rnd ? (($urandom_range(0, 3) != 0) || k >= 200) : (k >= 64 || !stall[k]);
    i = 0; c = 0;
    while (i <= int'(len)) begin
      c++;
      idx_at[c] = i;
      if (rdy[c]) i++;
    end
    c_last = c;
    done_c = c_last + (st ? 1 : 2);
    if (!st) begin
      exp_vec = '0;
      for (int l = 0; l <= int'(len); l++) exp_vec[l*EW +: EW] = mem_fn(addr_of(base, stride, l));
    end

    Start = 1'b1; IsStore = st; Base = base; Stride = stride; Len = len; VecIn = vec; MemReady = 1'b0;
    @(posedge Clk1); #1;
    Start = 1'b0; Base = ~base; VecIn = ~vec; Len = ~len;
    pend = 1'b0; pend_addr = '0; seen_done = -1;
    for (int cc = 1; cc <= done_c + 1; cc++) begin
      MemReady = rdy[cc];
      DataIn   = pend ? mem_fn(pend_addr) : 16'hDEAD;
      if (busy_start && (cc == 2 || cc == done_c)) begin
        Start = 1'b1; IsStore = ~st; Base = 16'h7777; Len = 4'd1;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk1);
      chk($sformatf("strobes_c%0d", cc), {RD, WR, Busy, Done},
          {(!st && cc <= c_last), (st && cc <= c_last), (cc <= done_c), (cc == done_c)});
      if (cc <= c_last) begin
        chk($sformatf("addr_c%0d", cc), Addr, addr_of(base, stride, idx_at[cc]));
        if (st) chk($sformatf("wdata_c%0d", cc), dataOut, vec[idx_at[cc]*EW +: EW]);
      end
      if (cc >= done_c) chk($sformatf("vecout_c%0d", cc), VecOut, exp_vec);
      if (Done && seen_done < 0) seen_done = cc;
      pend = RD && MemReady;
      pend_addr = Addr;
      @(posedge Clk1); #1;
    end
    Start = 1'b0;
    chk("done_cycle", seen_done, (tbl_done > 0) ? tbl_done : done_c);
  endtask

  initial begin
    vec_t tbl [5];
    logic [VW-1:0] v;
    tbl[0] = '{1'b0, 16'h0010, 16'h0001, 4'd15, 64'h0, 1'b0, 18};
    tbl[1] = '{1'b1, 16'h0001, 16'hFFFF, 4'd3,  64'h0, 1'b0, 5};
    tbl[2] = '{1'b0, 16'h0040, 16'h0002, 4'd2,  64'hA, 1'b0, 7};
    tbl[3] = '{1'b0, 16'h0200, 16'h0003, 4'd5,  64'h0, 1'b1, 8};
    tbl[4] = '{1'b0, 16'h1234, 16'h0000, 4'd0,  64'h0, 1'b0, 3};

    Reset_n = 1'b0; Start = 1'b0; IsStore = 1'b0; Base = '0; Stride = '0; Len = '0;
    VecIn = '0; MemReady = 1'b0; DataIn = '0;
    repeat (3) @(posedge Clk1);
    #1;
    chk("reset_outs", {Addr, RD, WR, dataOut, Busy, Done}, '0);
    chk("reset_vecout", VecOut, '0);
    Reset_n = 1'b1;
    @(posedge Clk1); #1;

    for (int t = 0; t < 5; t++) begin
      for (int l = 0; l < LANES; l++) v[l*EW +: EW] = 16'($urandom);
      if (t == 1) begin
        v[0*EW +: EW] = 16'hAAAA; v[1*EW +: EW] = 16'hBBBB;
        v[2*EW +: EW] = 16'hCCCC; v[3*EW +: EW] = 16'hDDDD;
      end
      run_op(tbl[t].st, tbl[t].base, tbl[t].stride, tbl[t].len, v, tbl[t].stall, 1'b0,
             tbl[t].busy_start, tbl[t].exp_done);
    end

    // Reset mid-store: strobes drop asynchronously, no Done.
    for (int l = 0; l < LANES; l++) v[l*EW +: EW] = 16'($urandom);
    Start = 1'b1; IsStore = 1'b1; Base = 16'h0300; Stride = 16'h0004; Len = 4'd7; VecIn = v;
    MemReady = 1'b1;
    @(posedge Clk1); #1;
    Start = 1'b0;
    @(posedge Clk1); #1;
    chk("pre_reset_wr", WR, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("midreset_outs", {Addr, RD, WR, Busy, Done}, '0);
    exp_vec = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk1);
      chk("midreset_nodone", {Busy, Done}, 2'b00);
    end
    @(posedge Clk1); #1;
    Reset_n = 1'b1;
    @(posedge Clk1); #1;
    run_op(1'b1, 16'h0500, 16'h0010, 4'd7, v, 64'h0, 1'b0, 1'b0, 9);

    for (int t = 0; t < 20; t++) begin
      for (int l = 0; l < LANES; l++) v[l*EW +: EW] = 16'($urandom);
      run_op(1'($urandom), 16'($urandom), 16'($urandom_range(0, 7) == 0 ? 0 : $urandom),
             4'($urandom), v, 64'h0, 1'b1, 1'($urandom_range(0, 3) == 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
